// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one cyc/stb/ack memory bus between the openmips
// instruction-fetch port and data-memory port. One transaction at a time,
// data port has fixed priority, each transaction bounded by an ack timeout.
module mips_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    // Instruction-fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,

    // Data-memory requester
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ready_o,

    // Shared bus master
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,

    // Pipeline control
    output logic              stallreq_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUS_IF  = 2'd1;
    localparam logic [1:0] BUS_MEM = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state;
    logic [7:0] to_cnt;
    logic [7:0] to_cnt_inc;
    logic       bus_timeout;
    logic       bus_finish;

    // The count this BUS cycle would reach without an ack; reaching TIMEOUT ends it.
    assign to_cnt_inc  = to_cnt + 8'd1;
    assign bus_timeout = !bus_ack_i && (to_cnt_inc == TIMEOUT_CNT);
    assign bus_finish  = bus_ack_i || bus_timeout;

    // Strobe is never separate from the cycle on this bus.
    assign bus_stb_o = bus_cyc_o;

    // Stall while any requester waits; its own ready pulse releases it that cycle.
    assign stallreq_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);

    // Arbitration FSM with registered bus, data and pulse outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            to_cnt      <= 8'd0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            if_data_o   <= '0;
            if_ready_o  <= 1'b0;
            mem_data_o  <= '0;
            mem_ready_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // Pulses default low so they last exactly one cycle.
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            err_o       <= 1'b0;

            case (state)
                IDLE: begin
                    // The MEM stage holds the older instruction, so it wins.
                    if (mem_req_i) begin
                        state      <= BUS_MEM;
                        to_cnt     <= 8'd0;
                        bus_cyc_o  <= 1'b1;
                        bus_we_o   <= mem_we_i;
                        bus_sel_o  <= mem_sel_i;
                        bus_addr_o <= mem_addr_i;
                        bus_data_o <= mem_data_i;
                    end else if (if_req_i) begin
                        state      <= BUS_IF;
                        to_cnt     <= 8'd0;
                        bus_cyc_o  <= 1'b1;
                        bus_we_o   <= 1'b0;
                        bus_sel_o  <= 4'hF;
                        bus_addr_o <= if_addr_i;
                        bus_data_o <= '0;
                    end
                end

                BUS_IF, BUS_MEM: begin
                    if (bus_finish) begin
                        state     <= DONE;
                        bus_cyc_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                        if (state == BUS_IF) begin
                            if_ready_o <= 1'b1;
                            if_data_o  <= bus_ack_i ? bus_data_i : '0;
                        end else begin
                            mem_ready_o <= 1'b1;
                            // A timeout zeroes read data even for writes;
                            // an acked write leaves it untouched.
                            if (!bus_ack_i) begin
                                mem_data_o <= '0;
                            end else if (!bus_we_o) begin
                                mem_data_o <= bus_data_i;
                            end
                        end
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end

                // One quiet cycle so a request still held from the pipeline
                // edge is not served twice.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed bench with a completion scoreboard for the
// openmips fetch/data bus arbiter.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        stallreq_o;
    logic        err_o;

    mips_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_ready_o (if_ready_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_sel_i  (mem_sel_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_ready_o(mem_ready_o),
        .bus_cyc_o  (bus_cyc_o),
        .bus_stb_o  (bus_stb_o),
        .bus_we_o   (bus_we_o),
        .bus_sel_o  (bus_sel_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_data_i (bus_data_i),
        .bus_ack_i  (bus_ack_i),
        .stallreq_o (stallreq_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Expected completion: which port, returned data, error flag.
    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   n_if_ready  = 0;
    int   n_mem_ready = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic is_mem, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_mem = is_mem;
        e.data   = data;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // Advance one cycle, sample 1ns after the edge, retire any completion.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (if_ready_o || mem_ready_o) begin
            if (if_ready_o)  n_if_ready++;
            if (mem_ready_o) n_mem_ready++;
            check("one_ready_at_a_time", {31'd0, if_ready_o & mem_ready_o}, 32'd0);
            check("ready_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ready_port", {31'd0, mem_ready_o}, {31'd0, e.is_mem});
                check("ready_data", mem_ready_o ? mem_data_o : if_data_o, e.data);
                check("ready_err", {31'd0, err_o}, {31'd0, e.err});
            end
        end else begin
            check("err_without_ready", {31'd0, err_o}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        mem_req_i  = 1'b0;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'h0;
        mem_addr_i = '0;
        mem_data_i = '0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, bus_stb_o}, 32'd0);
        check("rst_we", {31'd0, bus_we_o}, 32'd0);
        check("rst_sel", {28'd0, bus_sel_o}, 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_bus_data", bus_data_o, 32'd0);
        check("rst_if_ready", {31'd0, if_ready_o}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready_o}, 32'd0);
        check("rst_if_data", if_data_o, 32'd0);
        check("rst_mem_data", mem_data_o, 32'd0);
        check("rst_stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Single fetch, slave acks one cycle after the strobe
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0010;
        push_exp(1'b0, 32'h3401_0001, 1'b0);
        #1;
        check("t1_stall_pending", {31'd0, stallreq_o}, 32'd1);
        tick();
        check("t1_cyc_c1", {31'd0, bus_cyc_o}, 32'd1);
        check("t1_stb_c1", {31'd0, bus_stb_o}, 32'd1);
        check("t1_addr", bus_addr_o, 32'h0000_0010);
        check("t1_we", {31'd0, bus_we_o}, 32'd0);
        check("t1_sel", {28'd0, bus_sel_o}, 32'hF);
        tick();
        check("t1_cyc_c2", {31'd0, bus_cyc_o}, 32'd1);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h3401_0001;
        tick();
        bus_ack_i = 1'b0;
        check("t1_if_ready_c3", {31'd0, if_ready_o}, 32'd1);
        check("t1_cyc_c3", {31'd0, bus_cyc_o}, 32'd0);
        check("t1_stall_c3", {31'd0, stallreq_o}, 32'd0);
        if_req_i = 1'b0;
        tick();
        check("t1_ready_pulse_end", {31'd0, if_ready_o}, 32'd0);
        check("t1_if_data_hold", if_data_o, 32'h3401_0001);

        // Simultaneous requests: data port first, then fetch
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0200;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h0000_0100;
        push_exp(1'b1, 32'hA5A5_0100, 1'b0);
        push_exp(1'b0, 32'h1111_2222, 1'b0);
        tick();
        check("t2_cyc_c1", {31'd0, bus_cyc_o}, 32'd1);
        check("t2_mem_addr", bus_addr_o, 32'h0000_0100);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hA5A5_0100;
        tick();
        bus_ack_i = 1'b0;
        check("t2_mem_ready_c2", {31'd0, mem_ready_o}, 32'd1);
        check("t2_cyc_c2", {31'd0, bus_cyc_o}, 32'd0);
        check("t2_stall_c2", {31'd0, stallreq_o}, 32'd1);
        mem_req_i = 1'b0;
        tick();
        check("t2_cyc_c3", {31'd0, bus_cyc_o}, 32'd0);
        tick();
        check("t2_cyc_c4", {31'd0, bus_cyc_o}, 32'd1);
        check("t2_if_addr", bus_addr_o, 32'h0000_0200);
        check("t2_if_sel", {28'd0, bus_sel_o}, 32'hF);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h1111_2222;
        tick();
        bus_ack_i = 1'b0;
        check("t2_if_ready_c5", {31'd0, if_ready_o}, 32'd1);
        if_req_i = 1'b0;
        tick();
        check("t2_mem_data_hold", mem_data_o, 32'hA5A5_0100);

        // Partial write: bus fields stable until ack, read data untouched
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'b0011;
        mem_addr_i = 32'h0000_0040;
        mem_data_i = 32'hDEAD_BEEF;
        push_exp(1'b1, 32'hA5A5_0100, 1'b0);
        tick();
        mem_data_i = 32'h0;
        mem_sel_i  = 4'h0;
        mem_we_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_cyc", {31'd0, bus_cyc_o}, 32'd1);
            check("t3_we", {31'd0, bus_we_o}, 32'd1);
            check("t3_sel", {28'd0, bus_sel_o}, 32'h3);
            check("t3_wdata", bus_data_o, 32'hDEAD_BEEF);
            check("t3_addr", bus_addr_o, 32'h0000_0040);
            tick();
        end
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h1234_5678;
        tick();
        bus_ack_i = 1'b0;
        check("t3_mem_ready", {31'd0, mem_ready_o}, 32'd1);
        mem_req_i = 1'b0;
        tick();

        // Timeout: read never acked
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h0000_0080;
        push_exp(1'b1, 32'h0000_0000, 1'b1);
        tick();
        n = 0;
        while (bus_cyc_o && n < 40) begin
            n++;
            tick();
        end
        check("t4_cyc_cycles", 32'(n), 32'd15);
        check("t4_mem_ready", {31'd0, mem_ready_o}, 32'd1);
        check("t4_err", {31'd0, err_o}, 32'd1);
        mem_req_i = 1'b0;
        tick();
        check("t4_err_pulse_end", {31'd0, err_o}, 32'd0);
        check("t4_mem_data_zero", mem_data_o, 32'd0);

        // Reset mid-transaction, then a late ack in IDLE
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0300;
        tick();
        check("t5_cyc_before", {31'd0, bus_cyc_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("t5_cyc_reset", {31'd0, bus_cyc_o}, 32'd0);
        check("t5_stb_reset", {31'd0, bus_stb_o}, 32'd0);
        check("t5_if_ready_reset", {31'd0, if_ready_o}, 32'd0);
        rst        = 1'b0;
        if_req_i   = 1'b0;
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hBAD0_BAD0;
        tick();
        check("t5_cyc_late_ack", {31'd0, bus_cyc_o}, 32'd0);
        check("t5_if_ready_late_ack", {31'd0, if_ready_o}, 32'd0);
        bus_ack_i = 1'b0;
        tick();
        check("t5_if_data_cleared", if_data_o, 32'd0);

        // Held fetch request: one quiet DONE cycle, then a fresh grant
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0400;
        push_exp(1'b0, 32'hCAFE_0001, 1'b0);
        tick();
        check("t6_cyc_first", {31'd0, bus_cyc_o}, 32'd1);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hCAFE_0001;
        tick();
        bus_ack_i = 1'b0;
        check("t6_if_ready_first", {31'd0, if_ready_o}, 32'd1);
        if_addr_i = 32'h0000_0404;
        push_exp(1'b0, 32'hCAFE_0002, 1'b0);
        tick();
        check("t6_no_grant_after_done", {31'd0, bus_cyc_o}, 32'd0);
        check("t6_stall_idle", {31'd0, stallreq_o}, 32'd1);
        tick();
        check("t6_cyc_second", {31'd0, bus_cyc_o}, 32'd1);
        check("t6_addr_second", bus_addr_o, 32'h0000_0404);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hCAFE_0002;
        tick();
        bus_ack_i = 1'b0;
        check("t6_if_ready_second", {31'd0, if_ready_o}, 32'd1);
        if_req_i = 1'b0;
        tick();
        tick();

        // Every expected completion retired, none extra
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("if_ready_total", 32'(n_if_ready), 32'd4);
        check("mem_ready_total", 32'(n_mem_ready), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Shares one 32-bit single-port memory bus (cyc/stb/ack handshake, multi-cycle slave) between the instruction-fetch port and the data-memory port of the openmips core. It sequences one bus transaction at a time and returns data with a one-cycle ready pulse. It raises a stall request to the pipeline controller while any request is outstanding, and bounds each transaction with an ack timeout.

Parameters:
ADDR_W, 32, address width of both requesters and bus
DATA_W, 32, data width
TIMEOUT, 15, max cycles waiting for bus_ack_i before forced termination (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
if_req_i  input  1  fetch request, held until if_ready_o
if_addr_i  input  ADDR_W  fetch address
if_data_o  output  DATA_W  fetched instruction
if_ready_o  output  1  one-cycle completion pulse for fetch
mem_req_i  input  1  data request, held until mem_ready_o
mem_we_i  input  1  1 = write
mem_sel_i  input  4  byte enables
mem_addr_i  input  ADDR_W  data address
mem_data_i  input  DATA_W  write data
mem_data_o  output  DATA_W  read data
mem_ready_o  output  1  one-cycle completion pulse for data
bus_cyc_o  output  1  bus cycle active
bus_stb_o  output  1  strobe (equal to bus_cyc_o)
bus_we_o  output  1  write enable
bus_sel_o  output  4  byte enables
bus_addr_o  output  ADDR_W  address
bus_data_o  output  DATA_W  write data
bus_data_i  input  DATA_W  read data
bus_ack_i  input  1  slave acknowledge
stallreq_o  output  1  pipeline stall request
err_o  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction aborts it: cyc/stb low after that edge, no ready pulse.
- FSM states: IDLE, BUS_IF, BUS_MEM, DONE. All outputs registered except stallreq_o.
- IDLE: mem_req_i has fixed priority over if_req_i, because the MEM stage holds the older instruction. On a grant, latch addr/we/sel/data of the winner onto bus_* and set cyc=stb=1; go to BUS_MEM or BUS_IF. Fetch always uses we=0 and sel=4'hF.
- BUS_x: bus_* stay stable. When bus_ack_i is sampled high:
  - Clear cyc/stb.
  - On reads, capture bus_data_i into the winner's data_o.
  - Pulse the winner's ready_o in the next cycle, which is DONE.
  - Writes leave mem_data_o unchanged.
- Timeout: counter increments each BUS cycle without ack and is cleared on grant. When count reaches TIMEOUT:
  - Clear cyc/stb.
  - Set the winner's data_o to 0 (even on a write).
  - Pulse ready_o and err_o together in DONE.
- DONE: exactly one cycle. No new grant is made, so a request still high from the pipeline edge is not re-served. Then go to IDLE.
- Latency: request seen in IDLE at cycle 0, cyc at cycle 1; ack at cycle 1 gives ready at cycle 2. The minimum back-to-back period is 3 cycles.
- data_o holds its value until the next completed read (or timeout) for that port.
- bus_ack_i is ignored in IDLE and DONE.
- A requester that drops req mid-transaction does not abort it; the transaction completes and the ready pulse is still issued.
- stallreq_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o), combinational.

Test Plan:
- Single fetch: if_req_i=1, addr 0x00000010, slave acks the cycle after stb with 0x34010001 -> cyc high cycles 1-2, if_ready_o pulse at cycle 3, if_data_o=0x34010001, stallreq_o low from cycle 3.
- Simultaneous requests: if_req and mem read at 0x100 in same cycle, immediate acks -> mem served first (mem_ready cycle 2), fetch granted cycle 4, if_ready cycle 5; no overlapping cyc.
- Write: mem_we=1, sel=4'b0011, data 0xDEADBEEF -> bus_we_o=1, bus_sel_o=0011, bus_data_o=0xDEADBEEF held until ack; mem_data_o unchanged.
- Timeout: mem read, ack never asserted -> cyc drops after 15 BUS cycles; mem_ready_o and err_o pulse together, mem_data_o=0.
- Reset mid-transaction: rst=1 while BUS_IF before ack -> cyc/stb/ready all 0 next cycle, state IDLE; a late ack is ignored.
- Held request: if_req_i stays high across ready -> exactly one DONE cycle with no grant, then a new fetch grant in IDLE.
